// File: rtl/rx_word_packer.sv
`default_nettype none
// ============================================================================
// rx_word_packer : packs UART receive bytes into words on a valid/ready output
// Rev 1.0
// ============================================================================
module rx_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                                  i_Clock,
  input  logic                                  i_Rst_n,
  input  logic                                  i_Rx_DV,
  input  logic [7:0]                            i_Rx_Byte,
  input  logic                                  i_Flush,
  output logic [8*BYTES_PER_WORD-1:0]           o_Word,
  output logic                                  o_Word_Valid,
  input  logic                                  i_Word_Ready,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0]   o_Byte_Count,
  output logic                                  o_Overflow,
  output logic                                  o_Timeout
);

  localparam int c_N    = BYTES_PER_WORD;
  localparam int c_W    = 8 * c_N;
  localparam int c_CW   = $clog2(c_N + 1);
  localparam int c_TLIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int c_TW   = (c_TLIM > 0) ? $clog2(c_TLIM + 1) : 1;

  typedef enum logic [0:0] {
    ACCUM   = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t            r_state;
  logic [c_W-1:0]    r_accum;
  logic [c_W-1:0]    r_word;
  logic              r_valid;
  logic [c_CW-1:0]   r_count;
  logic [c_TW-1:0]   r_tcnt;
  logic              r_overflow;
  logic              r_timeout;

  logic [c_CW-1:0]   w_pos;
  logic [c_W-1:0]    w_ins_word;
  logic              w_expire;

  // A byte arriving on the pending-transfer edge starts the next word at lane 0.
  always_comb begin
    w_pos      = (r_state == PENDING) ? '0 : r_count;
    w_ins_word = r_accum;
    for (int k = 0; k < c_N; k++) begin
      if (w_pos == c_CW'(k)) begin
        w_ins_word[8*(MSB_FIRST ? (c_N-1-k) : k) +: 8] = i_Rx_Byte;
      end
    end
  end

  assign w_expire = (TIMEOUT_CYCLES > 0) && (r_state == ACCUM) && (r_count != '0) &&
                    !i_Rx_DV && (r_tcnt == c_TW'(c_TLIM));

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state    <= ACCUM;
      r_accum    <= '0;
      r_word     <= '0;
      r_valid    <= 1'b0;
      r_count    <= '0;
      r_tcnt     <= '0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
      if (r_valid && i_Word_Ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ACCUM: begin
          if (i_Flush) begin
            r_count <= '0;
            r_tcnt  <= '0;
          end else if (w_expire) begin
            r_count   <= '0;
            r_tcnt    <= '0;
            r_timeout <= 1'b1;
          end else if (i_Rx_DV) begin
            r_tcnt <= '0;
            if (r_count == c_CW'(c_N - 1)) begin
              if (!r_valid || i_Word_Ready) begin
                r_word  <= w_ins_word;
                r_valid <= 1'b1;
                r_count <= '0;
              end else begin
                r_accum <= w_ins_word;
                r_count <= c_CW'(c_N);
                r_state <= PENDING;
              end
            end else begin
              r_accum <= w_ins_word;
              r_count <= r_count + c_CW'(1);
            end
          end else if ((TIMEOUT_CYCLES > 0) && (r_count != '0)) begin
            r_tcnt <= r_tcnt + c_TW'(1);
          end else begin
            r_tcnt <= '0;
          end
        end

        PENDING: begin
          if (r_valid && i_Word_Ready) begin
            r_word  <= r_accum;
            r_valid <= 1'b1;
            r_state <= ACCUM;
            r_tcnt  <= '0;
            if (i_Rx_DV) begin
              r_accum <= w_ins_word;
              r_count <= c_CW'(1);
            end else begin
              r_count <= '0;
            end
          end else if (i_Rx_DV) begin
            r_overflow <= 1'b1;
          end
        end

        default: r_state <= ACCUM;
      endcase
    end
  end

  assign o_Word       = r_word;
  assign o_Word_Valid = r_valid;
  assign o_Byte_Count = r_count;
  assign o_Overflow   = r_overflow;
  assign o_Timeout    = r_timeout;

endmodule
`default_nettype wire

// File: doc/rx_word_packer.md
Name: rx_word_packer

Overview:
Parametrised byte-to-word packer between the UART receiver (byte strobe interface) and the APB-side command logic.
- Assembles BYTES_PER_WORD consecutive received bytes into one word, in a selectable byte order.
- Presents each finished word on a valid/ready handshake.
- One completed word can wait in the accumulator while the output register is held, so the two sides are decoupled.
- Adds partial-word flush, inter-byte timeout and overflow reporting.

Parameters:
BYTES_PER_WORD, 4, bytes per output word; legal range 2..8.
MSB_FIRST, 1, 1 = first received byte lands in the most significant byte; 0 = first byte lands in bits [7:0].
TIMEOUT_CYCLES, 0, idle clocks allowed between bytes of a partial word before it is discarded; 0 disables the timeout.

Ports:
i_Clock  in  1  system clock; all logic on the rising edge.
i_Rst_n  in  1  asynchronous active-low reset.
i_Rx_DV  in  1  single-cycle strobe; i_Rx_Byte is valid while this is high.
i_Rx_Byte  in  8  received byte.
i_Flush  in  1  synchronous discard of the partial word in the accumulator.
o_Word  out  8*BYTES_PER_WORD  assembled word; stable while o_Word_Valid=1.
o_Word_Valid  out  1  output register holds a word.
i_Word_Ready  in  1  consumer accepts o_Word on a cycle where o_Word_Valid=1.
o_Byte_Count  out  $clog2(BYTES_PER_WORD+1)  number of bytes currently in the accumulator.
o_Overflow  out  1  one-cycle pulse: a byte was dropped.
o_Timeout  out  1  one-cycle pulse: a partial word was discarded by the timeout.

Behaviour:
- Reset (i_Rst_n=0, asynchronous): all outputs 0, accumulator cleared, timeout counter cleared, pending flag cleared. Takes effect immediately, also in the middle of a word; the first byte after release becomes byte 0.
- Accumulator state machine: ACCUM (count < BYTES_PER_WORD) and PENDING (accumulator full, output register occupied).
- ACCUM, i_Rx_DV=1: the byte is stored at position count and count increments.
  - MSB_FIRST=1: byte k occupies bits [8*(N-1-k)+7 : 8*(N-1-k)], where N = BYTES_PER_WORD.
  - MSB_FIRST=0: byte k occupies bits [8k+7 : 8k].
- Completion (the byte that makes count reach N):
  - Output free, or freed on the same edge (o_Word_Valid & i_Word_Ready): the word including the incoming byte loads into o_Word on that edge. o_Word_Valid is high on the next cycle (1-cycle latency) and count returns to 0.
  - Otherwise: go to PENDING with o_Byte_Count = N.
- PENDING: on the edge where o_Word_Valid & i_Word_Ready, o_Word loads the pending word, o_Word_Valid stays 1, count goes to 0 and the state returns to ACCUM.
  - A byte arriving on that same edge is stored as byte 0 of the next word.
  - A byte arriving in PENDING with no handshake is dropped and o_Overflow pulses on the next cycle.
- Output register: o_Word_Valid falls after an accept unless a new word loads on the same edge. o_Word is unchanged while valid and not accepted.
- i_Flush:
  - ACCUM: clears count to 0; a simultaneous i_Rx_DV byte is discarded (flush wins, no overflow pulse).
  - PENDING: no effect, because the full word is preserved.
  - Never affects the output register.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter runs only in ACCUM with count>0; it clears on every accepted byte and whenever count=0.
  - After TIMEOUT_CYCLES consecutive cycles with no byte, count is cleared and o_Timeout pulses for one cycle.
  - A byte arriving on the expiry cycle is accepted and the timeout is cancelled.
- Simultaneous events, priority: reset > flush > timeout > byte capture.
- The output handshake is independent of the accumulator, except for the transfer rules above.

Test Plan:
- N=4, MSB_FIRST=1: bytes 0x12,0x34,0x56,0x78 on 4 consecutive cycles, i_Word_Ready=1 -> o_Word=0x12345678, o_Word_Valid high exactly one cycle, one cycle after the 0x78 strobe.
- Same stimulus with MSB_FIRST=0 -> o_Word=0x78563412. With N=2, bytes 0xAB,0xCD -> 0xABCD.
- i_Word_Ready=0: send 8 bytes 0x01..0x08 -> o_Word=0x01020304 held; o_Byte_Count=4; ninth byte 0x09 -> o_Overflow pulse, byte lost. Raise Ready -> next word 0x05060708, valid stays high.
- Ready=0 with a word pending; send byte 0xEE on the same cycle Ready rises -> pending word transferred, o_Byte_Count=1, 0xEE is byte 0 of the next word.
- TIMEOUT_CYCLES=10: send 2 bytes, then idle 10 cycles -> o_Timeout pulse, o_Byte_Count=0. Send a byte on the tenth idle cycle -> no timeout, count=3.
- Send 3 bytes, then assert i_Flush together with a byte -> count=0, no word, no overflow. Assert i_Rst_n=0 mid-word -> all outputs 0 asynchronously; the next 4 bytes form a clean word.
